// File: rtl/decoder_2to4_reg_pkg.sv
// Shared types and widths for the registered 2-to-4 decoder.
package decoder_2to4_reg_pkg;

  localparam int unsigned IDX_W    = 2;
  localparam int unsigned ONEHOT_W = 4;

  // Output register occupancy: EMPTY means y holds nothing, FULL means y is valid.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage : decoder_2to4_reg_pkg

// File: rtl/onehot_dec2to4.sv
// Combinational index-to-one-hot decode.
module onehot_dec2to4
  import decoder_2to4_reg_pkg::*;
(
  input  logic [IDX_W-1:0]    idx_i,
  output logic [ONEHOT_W-1:0] onehot_o
);

  // Map each index to its single set bit.
  always_comb begin
    onehot_o = '0;
    unique case (idx_i)
      2'd0: onehot_o = 4'b0001;
      2'd1: onehot_o = 4'b0010;
      2'd2: onehot_o = 4'b0100;
      2'd3: onehot_o = 4'b1000;
      default: onehot_o = '0;
    endcase
  end

endmodule : onehot_dec2to4

// File: rtl/decoder_2to4_reg.sv
// One-entry valid/ready pipeline stage that registers the one-hot decode of an
// encoded index, and tracks which indices were seen and how many were accepted.
module decoder_2to4_reg
  import decoder_2to4_reg_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    a_i,
  input  logic                valid_i,
  output logic                in_ready_o,
  output logic [ONEHOT_W-1:0] y_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  input  logic                clr_i,
  output logic [ONEHOT_W-1:0] seen_mask_o,
  output logic [CNT_W-1:0]    evt_cnt_o
);

  state_e              state_q, state_d;
  logic [ONEHOT_W-1:0] y_q, y_d;
  logic [ONEHOT_W-1:0] seen_q, seen_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [ONEHOT_W-1:0] dec_onehot;
  logic                in_xfer;
  logic                out_xfer;

  onehot_dec2to4 u_dec (
    .idx_i    (a_i),
    .onehot_o (dec_onehot)
  );

  // Handshake: the register can take a new value when empty or when it is
  // being drained in the same cycle.
  always_comb begin
    in_ready_o  = (state_q == EMPTY) | out_ready_i;
    out_valid_o = (state_q == FULL);
    in_xfer     = valid_i & in_ready_o;
    out_xfer    = out_valid_o & out_ready_i;
  end

  // Next state of the output register and the bookkeeping counters.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    if (in_xfer) begin
      state_d = FULL;
      y_d     = dec_onehot;
    end else if (out_xfer) begin
      state_d = EMPTY;
      y_d     = '0;
    end

    // Clear acts first so a same-cycle transfer is still recorded.
    seen_d = clr_i ? '0 : seen_q;
    cnt_d  = clr_i ? '0 : cnt_q;
    if (in_xfer) begin
      seen_d = seen_d | dec_onehot;
      cnt_d  = cnt_d + CNT_W'(1);
    end
  end

  // All state, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      y_q     <= '0;
      seen_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
    end
  end

  assign y_o         = y_q;
  assign seen_mask_o = seen_q;
  assign evt_cnt_o   = cnt_q;

endmodule : decoder_2to4_reg

// File: tb/tb_decoder_2to4_reg.sv
// Self-checking bench for decoder_2to4_reg: a behavioural model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_decoder_2to4_reg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0]       a = 2'd0;
  logic             valid = 1'b0;
  logic             in_ready;
  logic [3:0]       y;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             clr = 1'b0;
  logic [3:0]       seen_mask;
  logic [CNT_W-1:0] evt_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  decoder_2to4_reg #(
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_i         (a),
    .valid_i     (valid),
    .in_ready_o  (in_ready),
    .y_o         (y),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .clr_i       (clr),
    .seen_mask_o (seen_mask),
    .evt_cnt_o   (evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the held index (-1 when nothing is held), the set of seen indices,
  // and the number of accepted transfers modulo 2^CNT_W.
  int         m_idx = -1;
  logic [3:0] m_seen = 4'b0;
  int         m_cnt = 0;
  logic       m_acc;

  assign m_acc = valid && ((m_idx < 0) || out_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idx  <= -1;
      m_seen <= 4'b0;
      m_cnt  <= 0;
    end else begin
      if (m_acc) m_idx <= int'(a);
      else if (out_ready) m_idx <= -1;
      m_seen <= (clr ? 4'b0 : m_seen) | (m_acc ? (4'b1 << a) : 4'b0);
      m_cnt  <= ((clr ? 0 : m_cnt) + (m_acc ? 1 : 0)) % CNT_MOD;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_out_valid", 32'(out_valid), 32'(m_idx >= 0));
      chk("m_y", 32'(y), (m_idx >= 0) ? (32'd1 << m_idx) : 32'd0);
      chk("m_in_ready", 32'(in_ready), 32'((m_idx < 0) || out_ready));
      chk("m_seen", 32'(seen_mask), 32'(m_seen));
      chk("m_cnt", 32'(evt_cnt), 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_y [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    // Reset, then idle with a=11 and valid low.
    #1 rst_n = 1'b0;
    a = 2'b11;
    repeat (2) step();
    #2 rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (5) step();
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_y", 32'(y), 32'd0);
    chk("idle_cnt", 32'(evt_cnt), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back full-throughput stream.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      valid = 1'b1;
      step();
      chk($sformatf("stream_y%0d", i), 32'(y), 32'(exp_y[i]));
    end
    chk("stream_seen", 32'(seen_mask), 32'hf);
    chk("stream_cnt", 32'(evt_cnt), 32'd4);
    valid = 1'b0;
    a = 2'b10;
    step();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_y", 32'(y), 32'd0);

    // Backpressure holds y and blocks the input.
    out_ready = 1'b0;
    a = 2'b10;
    valid = 1'b1;
    step();
    chk("bp_first_y", 32'(y), 32'h4);
    a = 2'b01;
    repeat (3) begin
      #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("bp_hold_y", 32'(y), 32'h4);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_next_y", 32'(y), 32'h2);
    chk("bp_cnt", 32'(evt_cnt), 32'd6);
    valid = 1'b0;
    step();

    // Clear together with a same-cycle transfer.
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_idle_seen", 32'(seen_mask), 32'd0);
    for (int i = 0; i < 9; i++) begin
      a = 2'(i % 3);
      valid = 1'b1;
      step();
    end
    chk("preclr_seen", 32'(seen_mask), 32'h7);
    chk("preclr_cnt", 32'(evt_cnt), 32'd9);
    clr = 1'b1;
    a = 2'b11;
    step();
    clr = 1'b0;
    chk("clr_xfer_seen", 32'(seen_mask), 32'h8);
    chk("clr_xfer_cnt", 32'(evt_cnt), 32'd1);

    // Clear while FULL must leave y alone.
    valid = 1'b0;
    out_ready = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_full_y", 32'(y), 32'h8);
    chk("clr_full_valid", 32'(out_valid), 32'd1);
    chk("clr_full_seen", 32'(seen_mask), 32'd0);

    // Asynchronous reset mid-cycle while FULL.
    #2 rst_n = 1'b0;
    #1;
    chk("async_y", 32'(y), 32'd0);
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_cnt", 32'(evt_cnt), 32'd0);
    #1 rst_n = 1'b1;
    #1 chk("async_in_ready", 32'(in_ready), 32'd1);

    // Counter wrap.
    step();
    out_ready = 1'b1;
    valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = 2'(i % 4);
      step();
    end
    chk("wrap_cnt", 32'(evt_cnt), 32'd0);
    a = 2'b01;
    step();
    chk("wrap_cnt_257", 32'(evt_cnt), 32'd1);
    valid = 1'b0;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_decoder_2to4_reg

// File: doc/decoder_2to4_reg.md
DECODER_2TO4_REG -- requirements
Module: decoder_2to4_reg

Interface
REQ-001 Parameter: CNT_W, default 8, width of the accepted-transfer counter.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  2  encoded index, as produced by the 4-to-2 priority encoder.
REQ-005 valid  input  1  a is meaningful; this is the encoder valid flag, used as the input-side valid.
REQ-006 in_ready  output  1  block can accept {a, valid} this cycle.
REQ-007 y  output  4  registered one-hot decode of the held index.
REQ-008 out_valid  output  1  y holds a decoded value.
REQ-009 out_ready  input  1  consumer accepts y this cycle.
REQ-010 clr  input  1  synchronous clear of seen_mask and evt_cnt.
REQ-011 seen_mask  output  4  sticky OR of every one-hot value accepted since the last reset or clr.
REQ-012 evt_cnt  output  CNT_W  count of accepted input transfers, modulo 2^CNT_W.

Function
REQ-013 State machine SHALL have 2 states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 An input transfer SHALL occur when valid=1 and in_ready=1 at a rising clk edge.
REQ-015 An output transfer SHALL occur when out_valid=1 and out_ready=1 at a rising clk edge.
REQ-016 in_ready SHALL be combinational: (state==EMPTY) or out_ready, which gives full throughput with a 1-entry pipeline register.
REQ-017 Latency SHALL be 1 cycle: an index accepted at edge N SHALL appear as y=(1<<a), out_valid=1 after edge N.
REQ-018 EMPTY SHALL go to FULL on an input transfer; otherwise EMPTY SHALL stay EMPTY.
REQ-019 FULL SHALL go to EMPTY on an output transfer with no input transfer.
REQ-020 FULL SHALL stay FULL, with y reloaded to the new one-hot value, on simultaneous output and input transfers.
REQ-021 FULL with out_ready=0 SHALL hold y stable, and in_ready SHALL be 0.
REQ-022 y SHALL be 4'b0000 whenever out_valid=0, and SHALL be exactly one-hot whenever out_valid=1.
REQ-023 valid=0 SHALL never change state, y, seen_mask or evt_cnt, regardless of the value of a.
REQ-024 On each input transfer, seen_mask SHALL OR in (1<<a), and evt_cnt SHALL add 1, wrapping from 2^CNT_W-1 to 0.
REQ-025 clr=1 SHALL zero seen_mask and evt_cnt at the edge; a same-cycle input transfer SHALL then apply, giving seen_mask=(1<<a) and evt_cnt=1.
REQ-026 clr SHALL NOT affect state, y or out_valid.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force state=EMPTY, out_valid=0, y=0000, seen_mask=0000 and evt_cnt=0.
REQ-028 Reset asserted in FULL SHALL discard the held value; no output transfer is implied.
REQ-029 After rst_n deasserts, in_ready SHALL be 1 on the first cycle.

Structure
REQ-030 A shared package SHALL hold the state enum (EMPTY, FULL) and the localparam IDX_W=2 / ONEHOT_W=4.
REQ-031 The combinational index-to-one-hot function SHALL be a sub-module, onehot_dec2to4, instantiated once.
REQ-032 All state SHALL be held in a single always block with async reset; no latches.

Verification
REQ-033 Reset then idle, valid=0, a=2'b11 for 5 cycles -> out_valid=0, y=0000, evt_cnt=0, in_ready=1.
REQ-034 out_ready=1; inputs a=00,01,10,11 on back-to-back cycles with valid=1 -> y=0001,0010,0100,1000 on consecutive cycles, seen_mask=1111, evt_cnt=4.
REQ-035 Backpressure: accept a=10, hold out_ready=0 for 3 cycles, drive a=01 with valid=1 -> y stays 0100 and in_ready=0; raise out_ready -> next y=0010.
REQ-036 Counter wrap, CNT_W=8: 256 transfers -> evt_cnt=0; the 257th transfer -> evt_cnt=1.
REQ-037 clr with a=11 accepted in the same cycle, after seen_mask=0111 and evt_cnt=9 -> seen_mask=1000, evt_cnt=1.
REQ-038 rst_n pulsed low mid-cycle while FULL with y=1000 -> y=0000 and out_valid=0 before the next clk edge.
